iterative_divider: RTL and testbench

// - Sequential radix-2 non-restoring integer divider; the inverse operation of the parallel multiplier.
// - Shares its operand conventions: WIDTH-bit operands, one Sign control selecting signed/unsigned.
// - Sits beside the multiplier in the arithmetic unit.
// - Trades area for latency: one quotient bit per clock, valid/ready on both sides.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/iterative_divider.sv | 142 ++++++++++++++
 tb/tb_iterative_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Edges from the accept cycle (counted as 1) until Out_Valid is seen.
    localparam int DIV_LATENCY = DIV_WIDTH + 3;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 non-restoring division step
//
// Ports:
//   p      : current signed partial remainder (WIDTH+1 bits, two's complement)
//   a_msb  : dividend bit shifted into the partial remainder this step
//   d      : divisor magnitude (unsigned)
//   p_next : partial remainder after shift and add/subtract
//   q_bit  : quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p,
    input  logic             a_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] d_ext;

    // The shifted value can exceed WIDTH+1 bits, but the add/sub result
    // always lies in [-d, d), so wrapping arithmetic yields the right value.
    assign shifted = {p[WIDTH-1:0], a_msb};
    assign d_ext   = {1'b0, d};
    assign p_next  = p[WIDTH] ? (shifted + d_ext) : (shifted - d_ext);
    assign q_bit   = ~p_next[WIDTH];

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - sequential radix-2 non-restoring integer divider
//
// Ports:
//   Clk, Rst_n             : clock (rising edge), asynchronous active-low reset
//   In_Valid / In_Ready    : operand handshake; Dividend, Divisor, Sign captured on accept
//   Sign                   : 1 = two's-complement operands, 0 = unsigned
//   Out_Valid / Out_Ready  : result handshake; results held stable while stalled
//   Quotient, Remainder    : truncated-toward-zero quotient, dividend-signed remainder
//   Div_By_Zero, Overflow  : status flags, meaningful only with Out_Valid
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             Sign,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_By_Zero,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state, state_nxt;

    logic             rdy;
    logic [WIDTH-1:0] dvd_q, dvs_q;
    logic             sign_q;
    logic             q_neg, r_neg, ovf_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] d_mag;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH:0]   p_step, p_fix;
    logic             q_bit;
    logic             accept;

    assign accept   = In_Valid && rdy;
    assign In_Ready = rdy;
    assign Out_Valid = (state == DONE);

    // Magnitude of the most-negative value wraps to itself, which is the
    // correct unsigned magnitude, so no extra bit is needed here.
    assign mag_dvd = (sign_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    assign mag_dvs = (sign_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

    // Final correction: a negative partial remainder is restored once.
    assign p_fix = p_q[WIDTH] ? (p_q + {1'b0, d_mag}) : p_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_q),
        .a_msb  (a_q[WIDTH-1]),
        .d      (d_mag),
        .p_next (p_step),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = PREP;
            PREP: state_nxt = (dvs_q == '0) ? DONE : ITER;
            ITER: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (Out_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            rdy         <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            sign_q      <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_q       <= 1'b0;
            p_q         <= '0;
            a_q         <= '0;
            d_mag       <= '0;
            cnt         <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            Div_By_Zero <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Registered ready keeps In_Ready low for the first cycle after reset.
            rdy   <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_q  <= Dividend;
                        dvs_q  <= Divisor;
                        sign_q <= Sign;
                    end
                end
                PREP: begin
                    q_neg <= sign_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg <= sign_q && dvd_q[WIDTH-1];
                    ovf_q <= sign_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}})
                                    && (dvs_q == '1);
                    p_q   <= '0;
                    a_q   <= mag_dvd;
                    d_mag <= mag_dvs;
                    cnt   <= CW'(WIDTH - 1);
                    if (dvs_q == '0) begin
                        Quotient    <= '1;
                        Remainder   <= dvd_q;
                        Div_By_Zero <= 1'b1;
                        Overflow    <= 1'b0;
                    end
                end
                ITER: begin
                    p_q <= p_step;
                    a_q <= {a_q[WIDTH-2:0], q_bit};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    Quotient    <= q_neg ? -a_q : a_q;
                    Remainder   <= r_neg ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
                    Div_By_Zero <= 1'b0;
                    Overflow    <= ovf_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider
module tb_iterative_divider;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic         Sign = 1'b0;
    logic         Out_Valid;
    logic         Out_Ready = 1'b0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Div_By_Zero;
    logic         Overflow;

    int n_vec = 0;
    int n_err = 0;

    iterative_divider #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Sign        (Sign),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_By_Zero (Div_By_Zero),
        .Overflow    (Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Golden model: plain integer division with the special cases handled first.
    function automatic void ref_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output logic o);
        int sdd, sdv;
        z = 1'b0;
        o = 1'b0;
        sdd = dd;
        sdv = dv;
        if (dv == '0) begin
            q = DIV_ZERO_QUOT;
            r = dd;
            z = 1'b1;
        end else if (s && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
            o = 1'b1;
        end else if (s) begin
            q = sdd / sdv;
            r = sdd % sdv;
        end else begin
            q = dd / dv;
            r = dd % dv;
        end
    endfunction

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!In_Ready && n < 100) begin
            step();
            n++;
        end
        if (!In_Ready) check("ready_timeout", {63'd0, In_Ready}, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic s,
                          input int hold);
        logic [W-1:0] eq, er;
        logic ez, eo;
        int cyc, exp_lat;
        ref_div(dd, dv, s, eq, er, ez, eo);
        exp_lat = (dv == '0) ? 2 : DIV_LATENCY;
        wait_ready();
        In_Valid = 1'b1;
        Dividend = dd;
        Divisor  = dv;
        Sign     = s;
        cyc = 0;
        do begin
            step();
            if (cyc == 0) begin
                In_Valid = 1'b0;
                Dividend = $urandom;
                Divisor  = $urandom;
                Sign     = ~s;
            end
            cyc++;
        end while (!Out_Valid && cyc < 80);
        check("latency", 64'(cyc), 64'(exp_lat));
        check("quotient", {32'd0, Quotient}, {32'd0, eq});
        check("remainder", {32'd0, Remainder}, {32'd0, er});
        check("flags", {62'd0, Div_By_Zero, Overflow}, {62'd0, ez, eo});
        for (int i = 0; i < hold; i++) begin
            In_Valid = 1'b1;
            Dividend = $urandom;
            Divisor  = $urandom;
            step();
            check("hold_state", {61'd0, Out_Valid, In_Ready, Div_By_Zero},
                  {61'd0, 1'b1, 1'b0, ez});
            check("hold_q", {32'd0, Quotient}, {32'd0, eq});
            check("hold_r", {32'd0, Remainder}, {32'd0, er});
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        step();
        Out_Ready = 1'b0;
        check("handover", {62'd0, Out_Valid, In_Ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [W-1:0] rd, rv;
        logic rs;
        bit seen;

        repeat (3) @(posedge Clk);
        #1;
        check("reset_outs", {Quotient, Remainder}, 64'd0);
        check("reset_ctl", {60'd0, In_Ready, Out_Valid, Div_By_Zero, Overflow}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("ready_pre_edge", {63'd0, In_Ready}, 64'd0);
        step();
        check("ready_post_edge", {63'd0, In_Ready}, 64'd1);

        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 0);
        run_op(32'd5, 32'd0, 1'b1, 0);
        run_op(32'd5, 32'd0, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'd100, 32'd7, 1'b0, 10);

        // Abandon an operation with reset partway through the iterations.
        wait_ready();
        In_Valid = 1'b1;
        Dividend = 32'd1234567;
        Divisor  = 32'd3;
        Sign     = 1'b0;
        step();
        In_Valid = 1'b0;
        repeat (13) step();
        Rst_n = 1'b0;
        #1;
        check("midrst_outs", {Quotient, Remainder}, 64'd0);
        check("midrst_ctl", {62'd0, Out_Valid, In_Ready}, 64'd0);
        repeat (2) step();
        @(negedge Clk);
        Rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Out_Valid) seen = 1'b1;
        end
        check("midrst_no_valid", {63'd0, seen}, 64'd0);
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0);

        for (int n = 0; n < 1000; n++) begin
            rd = $urandom;
            rv = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: rv = '0;
                1: rv = W'($urandom_range(1, 15));
                2: begin rd = 32'h8000_0000; rv = 32'hFFFF_FFFF; end
                3: rv = rv >> $urandom_range(0, 31);
                4: rd = rd >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(rd, rv, rs, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
